// File: rtl/abd_wr_dispatch.sv
// Bulk-data write dispatcher: decodes the target application from the write address,
// queues packets per application and reports dropped packets.
module abd_wr_dispatch #(
  parameter int NUM_APPS      = 4,
  parameter int APP_ADDR_BITS = 32,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_accept,
  input  logic [63:0]                       in_addr,
  input  logic [511:0]                      in_data,
  input  logic [63:0]                       in_strb,
  input  logic [NUM_APPS-1:0]               app_enable,
  output logic [NUM_APPS-1:0]               app_valid,
  input  logic [NUM_APPS-1:0]               app_ready,
  output logic [NUM_APPS*APP_ADDR_BITS-1:0] app_addr,
  output logic [NUM_APPS*512-1:0]           app_data,
  output logic [NUM_APPS*64-1:0]            app_strb,
  output logic                              drop_valid,
  output logic [1:0]                        drop_reason,
  output logic [31:0]                       drop_count
);

  localparam int IDX_W = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int EW    = APP_ADDR_BITS + 512 + 64;

  localparam logic [1:0] RSN_MISALIGNED = 2'b01;
  localparam logic [1:0] RSN_RANGE      = 2'b10;
  localparam logic [1:0] RSN_DISABLED   = 2'b11;

  logic [63:0]          upper;
  logic [IDX_W-1:0]     idx;
  logic                 misaligned;
  logic                 out_range;
  logic                 drop;
  logic [1:0]           reason;
  logic                 sel_full;
  logic                 sel_en;
  logic [NUM_APPS-1:0]  full;
  logic [NUM_APPS-1:0]  push;

  always_comb begin
    upper      = in_addr >> APP_ADDR_BITS;
    idx        = upper[IDX_W-1:0];
    misaligned = |in_addr[5:0];
    // The whole window-select field must name a real slot, not just its low IDX_W bits.
    out_range  = (|in_addr[63:37]) || (in_addr >= 64'h1F_C000_0000) ||
                 (upper >= 64'(NUM_APPS));
    sel_full   = 1'b0;
    sel_en     = 1'b0;
    for (int unsigned i = 0; i < NUM_APPS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_full = full[i];
        sel_en   = app_enable[i];
      end
    end
    drop   = misaligned || out_range || !sel_en;
    reason = misaligned ? RSN_MISALIGNED : (out_range ? RSN_RANGE : RSN_DISABLED);
    in_accept = !rst && in_valid && (drop || !sel_full);
    for (int unsigned i = 0; i < NUM_APPS; i++) begin
      push[i] = in_accept && !drop && (idx == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_APPS; g++) begin : g_app
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          pop;

    assign full[g]      = (cnt == CW'(FIFO_DEPTH));
    assign app_valid[g] = (cnt != '0);
    assign pop          = app_valid[g] && app_ready[g];

    always_ff @(posedge clk) begin
      if (push[g]) mem[wp] <= {in_addr[APP_ADDR_BITS-1:0], in_data, in_strb};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push[g]) wp <= wp + PW'(1);
        if (pop)     rp <= rp + PW'(1);
        if (push[g] && !pop)      cnt <= cnt + CW'(1);
        else if (!push[g] && pop) cnt <= cnt - CW'(1);
      end
    end

    assign app_addr[g*APP_ADDR_BITS +: APP_ADDR_BITS] = mem[rp][EW-1 -: APP_ADDR_BITS];
    assign app_data[g*512 +: 512]                     = mem[rp][64 +: 512];
    assign app_strb[g*64 +: 64]                       = mem[rp][63:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_valid  <= 1'b0;
      drop_reason <= 2'b00;
      drop_count  <= '0;
    end else begin
      drop_valid <= in_accept && drop;
      if (in_accept && drop) begin
        drop_reason <= reason;
        if (drop_count != '1) drop_count <= drop_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_abd_wr_dispatch.sv
// Directed self-checking bench for abd_wr_dispatch (NUM_APPS=4, 32-bit windows, depth 4).
module tb_abd_wr_dispatch;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_accept;
  logic [63:0]   in_addr;
  logic [511:0]  in_data;
  logic [63:0]   in_strb;
  logic [3:0]    app_enable;
  logic [3:0]    app_valid;
  logic [3:0]    app_ready;
  logic [127:0]  app_addr;
  logic [2047:0] app_data;
  logic [255:0]  app_strb;
  logic          drop_valid;
  logic [1:0]    drop_reason;
  logic [31:0]   drop_count;

  int errors = 0;
  int checks = 0;

  abd_wr_dispatch #(.NUM_APPS(4), .APP_ADDR_BITS(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_accept(in_accept),
    .in_addr(in_addr), .in_data(in_data), .in_strb(in_strb),
    .app_enable(app_enable), .app_valid(app_valid), .app_ready(app_ready),
    .app_addr(app_addr), .app_data(app_data), .app_strb(app_strb),
    .drop_valid(drop_valid), .drop_reason(drop_reason), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [511:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_strb  = '1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send(64'h0, 512'h0);
    cyc();
    cyc();
    checks++; if (in_accept !== 1'b0) begin errors++; $display("FAIL rst_accept got %b want 0", in_accept); end
    checks++; if (app_valid !== 4'b0000) begin errors++; $display("FAIL rst_app_valid got %b want 0000", app_valid); end
    checks++; if (drop_valid !== 1'b0) begin errors++; $display("FAIL rst_drop_valid got %b want 0", drop_valid); end
    checks++; if (drop_reason !== 2'b00) begin errors++; $display("FAIL rst_drop_reason got %b want 00", drop_reason); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL rst_drop_count got %0d want 0", drop_count); end
    in_valid = 1'b0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_deliver();
    logic [511:0] d;
    d = {16{32'hC0DE_0002}};
    send(64'h2_0000_0040, d);
    #1;
    checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL deliver_accept got %b want 1", in_accept); end
    cyc();
    in_valid = 1'b0;
    checks++; if (app_valid !== 4'b0100) begin errors++; $display("FAIL deliver_valid got %b want 0100", app_valid); end
    checks++; if (app_addr[64 +: 32] !== 32'h40) begin errors++; $display("FAIL deliver_addr got %h want 00000040", app_addr[64 +: 32]); end
    checks++; if (app_data[1024 +: 512] !== d) begin errors++; $display("FAIL deliver_data got %h want %h", app_data[1024 +: 32], d[31:0]); end
    checks++; if (app_strb[128 +: 64] !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL deliver_strb got %h want all ones", app_strb[128 +: 64]); end
    cyc();
    checks++; if (app_valid !== 4'b0000) begin errors++; $display("FAIL deliver_drain got %b want 0000", app_valid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      send(64'(k) << 32, 512'(k + 16));
      #1;
      checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d got %b want 1", k, in_accept); end
      cyc();
      checks++; if (app_valid !== 4'(1 << k)) begin errors++; $display("FAIL b2b_valid%0d got %b want %b", k, app_valid, 4'(1 << k)); end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    app_ready = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      send(64'h1_0000_0000 + 64'(k * 64), 512'(k + 100));
      #1;
      checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL bp_accept%0d got %b want 1", k, in_accept); end
      cyc();
    end
    send(64'h1_0000_0100, 512'(104));
    #1;
    checks++; if (in_accept !== 1'b0) begin errors++; $display("FAIL bp_stall got %b want 0", in_accept); end
    cyc();
    checks++; if (in_accept !== 1'b0) begin errors++; $display("FAIL bp_stall_hold got %b want 0", in_accept); end
    app_ready[1] = 1'b1;
    #1;
    checks++; if (in_accept !== 1'b0) begin errors++; $display("FAIL bp_no_bypass got %b want 0", in_accept); end
    checks++; if (app_addr[32 +: 32] !== 32'h0) begin errors++; $display("FAIL bp_head0 got %h want 00000000", app_addr[32 +: 32]); end
    cyc();
    checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL bp_accept5 got %b want 1", in_accept); end
    checks++; if (app_addr[32 +: 32] !== 32'h40) begin errors++; $display("FAIL bp_head1 got %h want 00000040", app_addr[32 +: 32]); end
    cyc();
    in_valid = 1'b0;
    for (int j = 2; j <= 4; j++) begin
      checks++; if (app_addr[32 +: 32] !== 32'(j * 64)) begin errors++; $display("FAIL bp_head%0d got %h want %h", j, app_addr[32 +: 32], 32'(j * 64)); end
      checks++; if (app_data[512 +: 32] !== 32'(j + 100)) begin errors++; $display("FAIL bp_data%0d got %h want %h", j, app_data[512 +: 32], 32'(j + 100)); end
      cyc();
    end
    checks++; if (app_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", app_valid[1]); end
  endtask

  task automatic test_drops();
    logic [63:0] addrs [3];
    logic [1:0]  rsn [3];
    addrs = '{64'h0_0000_0008, 64'h5_0000_0000, 64'h1F_C000_0000};
    rsn   = '{2'b01, 2'b10, 2'b10};
    for (int k = 0; k < 3; k++) begin
      send(addrs[k], 512'(k));
      #1;
      checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL drop_accept%0d got %b want 1", k, in_accept); end
      cyc();
      in_valid = 1'b0;
      checks++; if (drop_valid !== 1'b1) begin errors++; $display("FAIL drop_valid%0d got %b want 1", k, drop_valid); end
      checks++; if (drop_reason !== rsn[k]) begin errors++; $display("FAIL drop_reason%0d got %b want %b", k, drop_reason, rsn[k]); end
      checks++; if (app_valid !== 4'b0000) begin errors++; $display("FAIL drop_no_app%0d got %b want 0000", k, app_valid); end
      cyc();
    end
    checks++; if (drop_valid !== 1'b0) begin errors++; $display("FAIL drop_pulse got %b want 0", drop_valid); end
    checks++; if (drop_reason !== 2'b10) begin errors++; $display("FAIL drop_reason_hold got %b want 10", drop_reason); end
    checks++; if (drop_count !== 32'd3) begin errors++; $display("FAIL drop_count got %0d want 3", drop_count); end
  endtask

  task automatic test_disabled();
    app_ready[3] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send(64'h3_0000_0000 + 64'(k * 64), 512'(k + 300));
      cyc();
    end
    in_valid = 1'b0;
    app_enable[3] = 1'b0;
    send(64'h3_0000_0080, 512'(302));
    #1;
    checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL dis_accept got %b want 1", in_accept); end
    cyc();
    in_valid = 1'b0;
    checks++; if (drop_valid !== 1'b1) begin errors++; $display("FAIL dis_drop_valid got %b want 1", drop_valid); end
    checks++; if (drop_reason !== 2'b11) begin errors++; $display("FAIL dis_reason got %b want 11", drop_reason); end
    checks++; if (drop_count !== 32'd4) begin errors++; $display("FAIL dis_count got %0d want 4", drop_count); end
    checks++; if (app_valid !== 4'b1000) begin errors++; $display("FAIL dis_queued got %b want 1000", app_valid); end
    app_ready[3] = 1'b1;
    #1;
    checks++; if (app_addr[96 +: 32] !== 32'h0) begin errors++; $display("FAIL dis_head0 got %h want 00000000", app_addr[96 +: 32]); end
    cyc();
    checks++; if (app_addr[96 +: 32] !== 32'h40) begin errors++; $display("FAIL dis_head1 got %h want 00000040", app_addr[96 +: 32]); end
    checks++; if (app_data[1536 +: 32] !== 32'd301) begin errors++; $display("FAIL dis_data1 got %0d want 301", app_data[1536 +: 32]); end
    cyc();
    checks++; if (app_valid[3] !== 1'b0) begin errors++; $display("FAIL dis_drained got %b want 0", app_valid[3]); end
    app_enable[3] = 1'b1;
  endtask

  task automatic test_full_no_bypass();
    app_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(64'(k * 64), 512'(k + 500));
      cyc();
    end
    send(64'h100, 512'(504));
    app_ready[0] = 1'b1;
    #1;
    checks++; if (in_accept !== 1'b0) begin errors++; $display("FAIL full_stall got %b want 0", in_accept); end
    cyc();
    checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL full_accept got %b want 1", in_accept); end
    cyc();
    in_valid = 1'b0;
    for (int j = 2; j <= 4; j++) begin
      checks++; if (app_addr[0 +: 32] !== 32'(j * 64)) begin errors++; $display("FAIL full_head%0d got %h want %h", j, app_addr[0 +: 32], 32'(j * 64)); end
      cyc();
    end
    checks++; if (app_valid[0] !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", app_valid[0]); end
  endtask

  task automatic test_reset_flush();
    app_ready = 4'b1010;
    send(64'h0_0000_0000, 512'(700));
    cyc();
    send(64'h2_0000_0000, 512'(701));
    cyc();
    send(64'h0_0000_0001, 512'(702));
    cyc();
    in_valid = 1'b0;
    checks++; if (app_valid !== 4'b0101) begin errors++; $display("FAIL flush_pre got %b want 0101", app_valid); end
    rst = 1'b1;
    in_valid = 1'b1;
    cyc();
    checks++; if (app_valid !== 4'b0000) begin errors++; $display("FAIL flush_valid got %b want 0000", app_valid); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL flush_count got %0d want 0", drop_count); end
    checks++; if (in_accept !== 1'b0) begin errors++; $display("FAIL flush_accept got %b want 0", in_accept); end
    rst = 1'b0;
    app_ready = '1;
    send(64'h0_0000_0040, 512'(703));
    #1;
    checks++; if (in_accept !== 1'b1) begin errors++; $display("FAIL post_rst_accept got %b want 1", in_accept); end
    cyc();
    in_valid = 1'b0;
    checks++; if (app_valid !== 4'b0001) begin errors++; $display("FAIL post_rst_valid got %b want 0001", app_valid); end
    checks++; if (app_addr[0 +: 32] !== 32'h40) begin errors++; $display("FAIL post_rst_addr got %h want 00000040", app_addr[0 +: 32]); end
    checks++; if (app_data[0 +: 32] !== 32'd703) begin errors++; $display("FAIL post_rst_data got %0d want 703", app_data[0 +: 32]); end
    cyc();
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_addr    = '0;
    in_data    = '0;
    in_strb    = '0;
    app_enable = '1;
    app_ready  = '1;
    test_reset();
    test_deliver();
    test_back_to_back();
    test_backpressure();
    test_drops();
    test_disabled();
    test_full_no_bypass();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/abd_wr_dispatch.md
Name: abd_wr_dispatch

Overview:
- Sits directly downstream of the PCIS bulk-data write path.
- Consumes the flattened write packet stream (address, 512-bit data, strobes) and decodes the target application from the address.
- Buffers each packet in a per-application FIFO and presents it to that application's bulk-data write port with an application-local offset address.
- Drops illegal or disabled-target packets and reports them through a drop counter and per-drop status.

Parameters:
- NUM_APPS, 4, number of application slots (1..16).
- APP_ADDR_BITS, 32, log2 of each application's window in bytes; app index = in_addr[APP_ADDR_BITS +: IDX_W], IDX_W = max(1, clog2(NUM_APPS)).
- FIFO_DEPTH, 4, entries per application FIFO; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  write packet valid from the write path
- in_accept  out  1  packet consumed this cycle when in_valid && in_accept
- in_addr  in  64  byte address within BAR4 space
- in_data  in  512  write data
- in_strb  in  64  byte strobes
- app_enable  in  NUM_APPS  per-app enable; 0 = app absent or being swapped
- app_valid  out  NUM_APPS  per-app packet valid
- app_ready  in  NUM_APPS  per-app ready
- app_addr  out  NUM_APPS*APP_ADDR_BITS  packed local offsets (in_addr[APP_ADDR_BITS-1:0])
- app_data  out  NUM_APPS*512  packed data
- app_strb  out  NUM_APPS*64  packed strobes
- drop_valid  out  1  one-cycle pulse per dropped packet
- drop_reason  out  2  01 misaligned, 10 out of range, 11 app disabled
- drop_count  out  32  saturating count of dropped packets

Behaviour:
- Reset: in_accept=0 during reset; app_valid=0; drop_valid=0; drop_reason=00; drop_count=0. All FIFOs are flushed. In the cycle rst deasserts, in_accept follows the normal rule and all FIFOs are empty.
- Classification (combinational on the in_* fields), first match wins:
  - misaligned: in_addr[5:0]!=0.
  - out of range: in_addr[63:37]!=0, or in_addr >= 0x1F_C000_0000 (reserved top 1 GiB), or index >= NUM_APPS.
  - disabled: app_enable[index]==0.
  - otherwise: deliver.
- in_accept = in_valid && (drop || !full[index]). There is no bypass: a FIFO that is full blocks a push even if it pops in the same cycle.
- A blocked packet stalls the input (head-of-line). in_* fields must be held stable by the source until accepted.
- Deliver: the packet is pushed to FIFO[index]. app_valid[index] rises the cycle after acceptance when the FIFO was empty (latency 1). The output fields come from the registered FIFO head.
- App port handshake:
  - Pop when app_valid[i] && app_ready[i].
  - app_valid stays high and the head is stable until popped.
  - Order is preserved per app; there is no ordering between apps.
  - Simultaneous push and pop on a non-full FIFO keeps the occupancy unchanged.
- Drop:
  - The packet is accepted in the same cycle (no stall).
  - Next cycle: drop_valid=1 and drop_reason is set.
  - drop_count increments and saturates at 0xFFFF_FFFF.
  - drop_reason holds its value until the next drop.
- app_enable deasserting for an app does not flush that app's FIFO; already-queued packets still drain. Only new arrivals for that app are dropped.
- Back-to-back: one packet per cycle is sustained while target FIFOs are not full.
- Occupancy counters are clog2(FIFO_DEPTH)+1 bits wide; read and write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- NUM_APPS=4, all enabled, app_ready=1; in_addr=0x2_0000_0040 with data D, strb all-ones -> accepted cycle N; app_valid[2]=1 in cycle N+1 with app_addr[2]=0x40, data D; other app_valid=0.
- app_ready[1]=0; 5 back-to-back packets to 0x1_0000_0000 + k*0x40 -> first 4 accepted, in_accept=0 for the 5th. Raise app_ready[1] -> 5th accepted 1 cycle after the first pop; all 5 delivered in order with offsets 0x0..0x100.
- in_addr=0x0_0000_0008 -> drop_reason=01; in_addr=0x5_0000_0000 -> 10; in_addr=0x1F_C000_0000 -> 10; each accepted with no stall; drop_count=3; no app_valid.
- app_enable[3]=0 with 2 packets already queued for app 3; new packet to 0x3_0000_0000 -> drop_reason=11; both queued packets still drain.
- FIFO for app 0 full, app_ready[0]=1 and new packet to app 0 in the same cycle -> in_accept=0 that cycle, accepted the next cycle.
- rst asserted with packets queued in 2 FIFOs -> next cycle app_valid=0, drop_count=0; the first post-reset packet to app 0 is delivered with latency 1.
